// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-entry busy scoreboard.
// Optional same-cycle write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        d_in,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] d_out,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [DEPTH-1:0]         busy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  wr_dec, rsv_dec, rsv_grant;

    // Address decoders; an out-of-range address decodes to no entry at all.
    always_comb begin
        wr_dec  = '0;
        rsv_dec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_dec[i]  = wr && (wr_addr == ADDR_W'(i));
            rsv_dec[i] = rsv && (rsv_addr == ADDR_W'(i));
        end
    end

    assign rsv_grant = rsv_dec & ~busy_q;
    assign rsv_ok    = |rsv_grant;

    // Reservation is applied after the write clear: the newer producer wins.
    always_comb begin
        busy_d = (busy_q & ~wr_dec) | rsv_grant;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = wr_dec[i] ? d_in : mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy = busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr == ADDR_W'(i)) begin
                    data = mem_q[i];
                    bsy  = busy_q[i];
                end
            end
`ifdef REG_FILE_BYPASS_EN
            // Forwarding is suppressed under reset so outputs read as cleared.
            if (reset && (|wr_dec) && (addr == wr_addr)) begin
                data = d_in;
                bsy  = rsv_ok && (rsv_addr == addr);
            end
`endif
        end

        assign d_out[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb (DEPTH=8 main instance, DEPTH=6 range instance).
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        rsv;
    logic [2:0]  rsv_addr;
    logic [5:0]  rd_addr;

    logic        rsv_ok8, rsv_ok6;
    logic [31:0] d_out8, d_out6;
    logic [1:0]  rd_busy8, rd_busy6;
    logic [7:0]  busy8;
    logic [5:0]  busy6;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_sb #(.DATA_W(16), .DEPTH(8), .NUM_RD(2)) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok8), .rd_addr(rd_addr),
        .d_out(d_out8), .rd_busy(rd_busy8), .busy(busy8)
    );

    reg_file_sb #(.DATA_W(16), .DEPTH(6), .NUM_RD(2)) dut6 (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok6), .rd_addr(rd_addr),
        .d_out(d_out6), .rd_busy(rd_busy6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        rsv;
        logic [2:0]  ra;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic        ok;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        b0;
        logic        b1;
        logic [7:0]  bsy;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vt [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic r, input logic [2:0] ra, input logic [2:0] r0,
                         input logic [2:0] r1);
        wr = w; wr_addr = wa; d_in = wd; rsv = r; rsv_addr = ra; rd_addr = {r1, r0};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] e0, e1;
        logic        eb0, eb1;

        // Expected values are the pre-edge outputs for each row (no forwarding).
        vt[0]  = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd2,
                   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 3'd2,
                   1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd3,
                   1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 8'h20};
        vt[3]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd5,
                   1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'h20};
        vt[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd3,
                   1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 3'd6, 16'h00AA, 1'b1, 3'd6, 3'd6, 3'd5,
                   1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd1,
                   1'b0, 16'h00AA, 16'h0000, 1'b1, 1'b0, 8'h40};
        vt[7]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd7, 3'd0, 3'd7,
                   1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h40};
        vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd7,
                   1'b0, 16'h1111, 16'h0000, 1'b0, 1'b1, 8'hC0};
        vt[9]  = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd2, 3'd7, 3'd2,
                   1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'hC0};
        vt[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd7, 3'd2,
                   1'b0, 16'h7777, 16'h0000, 1'b0, 1'b1, 8'h44};

        // Reset held with active-looking inputs: everything reads zero, writes are lost.
        reset = 1'b0;
        drive(1'b1, 3'd3, 16'hFFFF, 1'b1, 3'd4, 3'd3, 3'd4);
        #3;
        chk("rst_dout", d_out8, 32'h0);
        chk("rst_rdbusy", 32'(rd_busy8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_rsvok", 32'(rsv_ok8), 32'h1);
        @(posedge clk); #1;
        chk("rst_edge_busy", 32'(busy8), 32'h0);
        chk("rst_edge_dout", d_out8, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd4);
        #1;
        chk("rst_rel_dout", d_out8, 32'h0);
        chk("rst_rel_busy", 32'(busy8), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rsv, vt[i].ra, vt[i].r0, vt[i].r1);
            e0 = vt[i].d0; e1 = vt[i].d1; eb0 = vt[i].b0; eb1 = vt[i].b1;
`ifdef REG_FILE_BYPASS_EN
            if (vt[i].wr && vt[i].r0 == vt[i].wa) begin
                e0 = vt[i].wd; eb0 = vt[i].ok && (vt[i].ra == vt[i].r0);
            end
            if (vt[i].wr && vt[i].r1 == vt[i].wa) begin
                e1 = vt[i].wd; eb1 = vt[i].ok && (vt[i].ra == vt[i].r1);
            end
`endif
            #1;
            chk($sformatf("v%0d_rsvok", i), 32'(rsv_ok8), 32'(vt[i].ok));
            chk($sformatf("v%0d_d0", i), 32'(d_out8[15:0]), 32'(e0));
            chk($sformatf("v%0d_d1", i), 32'(d_out8[31:16]), 32'(e1));
            chk($sformatf("v%0d_rb0", i), 32'(rd_busy8[0]), 32'(eb0));
            chk($sformatf("v%0d_rb1", i), 32'(rd_busy8[1]), 32'(eb1));
            chk($sformatf("v%0d_busy", i), 32'(busy8), 32'(vt[i].bsy));
        end

        // Same-cycle read of a register being written, then reset mid-burst.
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b1, 3'd2, 16'h5A5A, 1'b1, 3'd3, 3'd2, 3'd1);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("same_cyc_rd", 32'(d_out8[15:0]), 32'h5A5A);
`else
        chk("same_cyc_rd", 32'(d_out8[15:0]), 32'h0000);
`endif
        @(negedge clk);
        drive(1'b1, 3'd1, 16'h1357, 1'b1, 3'd4, 3'd2, 3'd1);
        #1;
        chk("burst_rd2", 32'(d_out8[15:0]), 32'h5A5A);
        chk("burst_busy", 32'(busy8), 32'h08);
        #1 reset = 1'b0;
        #1;
        chk("midrst_dout", d_out8, 32'h0);
        chk("midrst_busy", 32'(busy8), 32'h0);
        @(posedge clk); #1;
        chk("midrst_edge_dout", d_out8, 32'h0);
        chk("midrst_edge_busy", 32'(busy8), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd1);
        #1;
        chk("midrst_rel_dout", d_out8, 32'h0);

        // Out-of-range accesses on the DEPTH=6 instance.
        @(negedge clk);
        drive(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 3'd0, 3'd7);
        #1;
        chk("d6_rsvok_oor", 32'(rsv_ok6), 32'h0);
        chk("d6_rd_oor", 32'(d_out6[31:16]), 32'h0);
        chk("d6_rb_oor", 32'(rd_busy6[1]), 32'h0);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
        #1;
        chk("d6_busy_after", 32'(busy6), 32'h0);
        chk("d6_regs_after", d_out6, 32'h0);
        @(negedge clk);
        drive(1'b1, 3'd6, 16'hABCD, 1'b1, 3'd5, 3'd6, 3'd5);
        #1;
        chk("d6_rsvok_in", 32'(rsv_ok6), 32'h1);
        chk("d6_rd6_oor", 32'(d_out6[15:0]), 32'h0);
        @(negedge clk);
        drive(1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd0, 3'd5);
        #1;
        chk("d6_busy5", 32'(busy6), 32'h20);
        chk("d6_rb5", 32'(rd_busy6[1]), 32'h1);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd5);
        #1;
        chk("d6_rd5", 32'(d_out6[31:16]), 32'h5555);
        chk("d6_busy_clr", 32'(busy6), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
